// File: rtl/arbitro_de_funcionalidades_seq_if.sv
// Request/grant bundle between the user channels and the function arbiter.
// The master drives per-channel codes and functions. The slave (the arbiter) reports ownership.
interface arbitro_de_funcionalidades_seq_if #(
  parameter int NUM_USERS = 4,
  parameter int USER_W    = 3,
  parameter int FUNC_W    = 3
);
  logic [NUM_USERS*USER_W-1:0] UserCodes;
  logic [NUM_USERS*FUNC_W-1:0] Funcs;
  logic [NUM_USERS-1:0]        Grant;
  logic [NUM_USERS-1:0]        Espera;
  logic [2**FUNC_W-1:0]        FuncAtiva;
  logic                        BloqueadoValido;
  logic [USER_W-1:0]           BloqueadoCodigo;

  modport master (
    output UserCodes, Funcs,
    input  Grant, Espera, FuncAtiva, BloqueadoValido, BloqueadoCodigo
  );

  modport slave (
    input  UserCodes, Funcs,
    output Grant, Espera, FuncAtiva, BloqueadoValido, BloqueadoCodigo
  );
endinterface

// File: rtl/arbitro_de_funcionalidades_seq.sv
// Registered function arbiter: each function goes to at most one user, and higher codes win.
// A grant is held for MIN_HOLD cycles before a strictly higher code may preempt it.
module arbitro_de_funcionalidades_seq #(
  parameter int NUM_USERS = 4,
  parameter int USER_W    = 3,
  parameter int FUNC_W    = 3,
  parameter int MIN_HOLD  = 4,
  parameter int PREEMPT   = 1
) (
  input  logic                                 Clock,
  input  logic                                 Reset,
  arbitro_de_funcionalidades_seq_if.slave      bus
);
  localparam int NUM_FUNCS = 2**FUNC_W;
  localparam int IDX_W     = $clog2(NUM_USERS);
  localparam int CNT_W     = $clog2(MIN_HOLD + 1);

  typedef logic [USER_W-1:0] code_t;
  typedef logic [FUNC_W-1:0] func_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef enum logic [1:0] {LIVRE, ESPERA, ATIVO} chan_st_e;

  code_t codes [NUM_USERS];
  func_t funcs [NUM_USERS];

  logic [NUM_FUNCS-1:0] own_vld, own_vld_n, keep;
  idx_t      own_idx   [NUM_FUNCS];
  idx_t      own_idx_n [NUM_FUNCS];
  cnt_t      hold_cnt  [NUM_FUNCS];
  cnt_t      hold_cnt_n[NUM_FUNCS];
  code_t     best_code [NUM_FUNCS];
  idx_t      best_idx  [NUM_FUNCS];
  chan_st_e  chan_st   [NUM_USERS];
  chan_st_e  chan_st_n [NUM_USERS];
  code_t     bloq_code, bloq_code_n;
  logic [NUM_USERS-1:0] grant_o, espera_o;

  always_comb begin
    for (int i = 0; i < NUM_USERS; i++) begin
      codes[i] = bus.UserCodes[i*USER_W +: USER_W];
      funcs[i] = bus.Funcs[i*FUNC_W +: FUNC_W];
    end
  end

  // Best requester per function. A strict compare keeps the lowest index on ties and skips code 0.
  always_comb begin
    for (int f = 0; f < NUM_FUNCS; f++) begin
      best_code[f] = '0;
      best_idx[f]  = '0;
      keep[f]      = own_vld[f] && (funcs[own_idx[f]] == func_t'(f)) && (codes[own_idx[f]] != '0);
      for (int i = 0; i < NUM_USERS; i++) begin
        if (funcs[i] == func_t'(f) && codes[i] > best_code[f]) begin
          best_code[f] = codes[i];
          best_idx[f]  = idx_t'(i);
        end
      end
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so that no latch is inferred.
    own_vld_n = '0;
    for (int f = 0; f < NUM_FUNCS; f++) begin
      own_idx_n[f]  = '0;
      hold_cnt_n[f] = '0;
    end
    for (int f = 1; f < NUM_FUNCS; f++) begin
      if (keep[f]) begin
        own_vld_n[f] = 1'b1;
        if (PREEMPT != 0 && hold_cnt[f] == cnt_t'(MIN_HOLD) && best_code[f] > codes[own_idx[f]]) begin
          own_idx_n[f]  = best_idx[f];
          hold_cnt_n[f] = cnt_t'(1);
        end else begin
          own_idx_n[f]  = own_idx[f];
          hold_cnt_n[f] = (hold_cnt[f] == cnt_t'(MIN_HOLD)) ? hold_cnt[f] : hold_cnt[f] + cnt_t'(1);
        end
      end else if (best_code[f] != '0) begin
        own_vld_n[f]  = 1'b1;
        own_idx_n[f]  = best_idx[f];
        hold_cnt_n[f] = cnt_t'(1);
      end
    end

    bloq_code_n = '0;
    for (int i = 0; i < NUM_USERS; i++) begin
      if (own_vld_n[funcs[i]] && own_idx_n[funcs[i]] == idx_t'(i))
        chan_st_n[i] = ATIVO;
      else if (funcs[i] != '0 && codes[i] != '0)
        chan_st_n[i] = ESPERA;
      else
        chan_st_n[i] = LIVRE;
      if (chan_st_n[i] == ESPERA && (bloq_code_n == '0 || codes[i] < bloq_code_n))
        bloq_code_n = codes[i];
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      // NOTE: the owner tables are reset too, because a reset must drop every grant at once.
      own_vld   <= '0;
      bloq_code <= '0;
      for (int f = 0; f < NUM_FUNCS; f++) begin
        own_idx[f]  <= '0;
        hold_cnt[f] <= '0;
      end
      for (int i = 0; i < NUM_USERS; i++) chan_st[i] <= LIVRE;
    end else begin
      // NOTE: registered state uses non-blocking assignments only, so every register sees pre-edge values.
      own_vld   <= own_vld_n;
      bloq_code <= bloq_code_n;
      for (int f = 0; f < NUM_FUNCS; f++) begin
        own_idx[f]  <= own_idx_n[f];
        hold_cnt[f] <= hold_cnt_n[f];
      end
      for (int i = 0; i < NUM_USERS; i++) chan_st[i] <= chan_st_n[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_USERS; i++) begin
      grant_o[i]  = (chan_st[i] == ATIVO);
      espera_o[i] = (chan_st[i] == ESPERA);
    end
  end

  assign bus.Grant           = grant_o;
  assign bus.Espera          = espera_o;
  assign bus.FuncAtiva       = own_vld;
  assign bus.BloqueadoValido = |espera_o;
  assign bus.BloqueadoCodigo = bloq_code;
endmodule
